// File: rtl/fft_r2_dif_seq.sv
// fft_r2_dif_seq: memory-based iterative radix-2 DIF FFT.
// A frame of 2^N_LOG2 complex samples is loaded, transformed in place at one
// butterfly per cycle (each stage scales by 1/2), then streamed out in natural
// or raw bit-reversed memory order.
module fft_r2_dif_seq #(
  parameter int N_LOG2     = 3,
  parameter int DW         = 16,
  parameter int TW_W       = 16,
  parameter int OUT_BITREV = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     in_real,
  input  logic [DW-1:0]     in_imag,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DW-1:0]     out_real,
  output logic [DW-1:0]     out_imag,
  output logic [N_LOG2-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int N  = 1 << N_LOG2;
  localparam int HN = N / 2;
  localparam int PW = DW + TW_W + 1;

  typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_COMPUTE = 2'd1, ST_UNLOAD = 2'd2} state_t;

  // Twiddle table W[k] = exp(-j*2*pi*k/N) scaled by 2^(TW_W-2), rounded to nearest.
  // sin/cos come from a Taylor series so only basic real arithmetic is needed.
  function automatic logic [HN*TW_W-1:0] make_twiddle(input logic want_sin);
    logic [HN*TW_W-1:0] rom;
    real x, term, acc, scale, v;
    int  iv;
    rom   = '0;
    scale = 1.0;
    for (int i = 0; i < TW_W - 2; i++) scale = scale * 2.0;
    for (int k = 0; k < HN; k++) begin
      x = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
      if (want_sin) begin
        term = x;
        acc  = x;
        for (int n = 1; n < 40; n++) begin
          term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
          acc  = acc + term;
        end
        v = -acc;
      end else begin
        term = 1.0;
        acc  = 1.0;
        for (int n = 1; n < 40; n++) begin
          term = -term * x * x / (real'(2 * n - 1) * real'(2 * n));
          acc  = acc + term;
        end
        v = acc;
      end
      v = v * scale;
      if (v >= 0.0) iv = $rtoi(v + 0.5);
      else          iv = -$rtoi(0.5 - v);
      rom[k*TW_W +: TW_W] = TW_W'(iv);
    end
    return rom;
  endfunction

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction

  localparam logic [HN*TW_W-1:0] TW_RE = make_twiddle(1'b0);
  localparam logic [HN*TW_W-1:0] TW_IM = make_twiddle(1'b1);

  logic signed [DW-1:0] mem_re_r [N];
  logic signed [DW-1:0] mem_im_r [N];

  state_t            state_r, state_nxt_s;
  logic [N_LOG2-1:0] cnt_r, bfly_r, k_r;
  logic [3:0]        stage_r;

  logic [N_LOG2-1:0]    half_s, hmask_s, p_s, q_s, tw_idx_s, k_load_s, rd_addr_s;
  logic signed [TW_W-1:0] w_re_s, w_im_s;
  logic signed [DW:0]   sum_re_s, sum_im_s, dif_re_s, dif_im_s;
  logic signed [PW-1:0] d_re_x_s, d_im_x_s, w_re_x_s, w_im_x_s, prod_re_s, prod_im_s;
  logic signed [DW-1:0] bf_p_re_s, bf_p_im_s, bf_q_re_s, bf_q_im_s, rd_re_s, rd_im_s;
  logic                 in_load_s, compute_end_s, accept_s, load_beat_s;

  logic [DW-1:0]     out_real_r, out_imag_r, out_real_nxt_s, out_imag_nxt_s;
  logic [N_LOG2-1:0] out_idx_r, out_idx_nxt_s;
  logic              out_valid_r, out_last_r, in_ready_r, busy_r, done_r;
  logic              out_valid_nxt_s, out_last_nxt_s, in_ready_nxt_s, busy_nxt_s, done_nxt_s;

  assign in_load_s     = (state_r == ST_LOAD) && in_valid;
  assign compute_end_s = (state_r == ST_COMPUTE) && (stage_r == 4'(N_LOG2 - 1)) &&
                         (bfly_r == N_LOG2'(HN - 1));
  assign accept_s      = (state_r == ST_UNLOAD) && out_valid_r && out_ready;
  assign load_beat_s   = compute_end_s || (accept_s && !out_last_r);

  // Butterfly pair addresses and twiddle index from stage and butterfly counters
  always_comb begin
    half_s   = N_LOG2'(N >> (stage_r + 4'd1));
    hmask_s  = half_s - N_LOG2'(1);
    p_s      = ((bfly_r & ~hmask_s) << 1'b1) | (bfly_r & hmask_s);
    q_s      = p_s | half_s;
    tw_idx_s = (bfly_r & hmask_s) << stage_r;
  end

  // Butterfly datapath: halved sum to p, halved difference times twiddle to q
  always_comb begin
    w_re_s    = TW_RE[tw_idx_s*TW_W +: TW_W];
    w_im_s    = TW_IM[tw_idx_s*TW_W +: TW_W];
    sum_re_s  = {mem_re_r[p_s][DW-1], mem_re_r[p_s]} + {mem_re_r[q_s][DW-1], mem_re_r[q_s]};
    sum_im_s  = {mem_im_r[p_s][DW-1], mem_im_r[p_s]} + {mem_im_r[q_s][DW-1], mem_im_r[q_s]};
    dif_re_s  = {mem_re_r[p_s][DW-1], mem_re_r[p_s]} - {mem_re_r[q_s][DW-1], mem_re_r[q_s]};
    dif_im_s  = {mem_im_r[p_s][DW-1], mem_im_r[p_s]} - {mem_im_r[q_s][DW-1], mem_im_r[q_s]};
    bf_p_re_s = sum_re_s[DW:1];
    bf_p_im_s = sum_im_s[DW:1];
    d_re_x_s  = PW'($signed(dif_re_s[DW:1]));
    d_im_x_s  = PW'($signed(dif_im_s[DW:1]));
    w_re_x_s  = PW'(w_re_s);
    w_im_x_s  = PW'(w_im_s);
    prod_re_s = d_re_x_s * w_re_x_s - d_im_x_s * w_im_x_s;
    prod_im_s = d_re_x_s * w_im_x_s + d_im_x_s * w_re_x_s;
    bf_q_re_s = prod_re_s[TW_W-2 +: DW];
    bf_q_im_s = prod_im_s[TW_W-2 +: DW];
  end

  // Output read address; bypass the butterfly being written on the last compute cycle
  always_comb begin
    if (state_r == ST_COMPUTE) k_load_s = '0;
    else                       k_load_s = k_r + N_LOG2'(1);
    if (OUT_BITREV != 0) rd_addr_s = k_load_s;
    else                 rd_addr_s = bitrev(k_load_s);
    if ((state_r == ST_COMPUTE) && (rd_addr_s == p_s)) begin
      rd_re_s = bf_p_re_s;
      rd_im_s = bf_p_im_s;
    end else if ((state_r == ST_COMPUTE) && (rd_addr_s == q_s)) begin
      rd_re_s = bf_q_re_s;
      rd_im_s = bf_q_im_s;
    end else begin
      rd_re_s = mem_re_r[rd_addr_s];
      rd_im_s = mem_im_r[rd_addr_s];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_LOAD;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (in_load_s && (cnt_r == N_LOG2'(N - 1))) state_nxt_s = ST_COMPUTE;
        else                                        state_nxt_s = ST_LOAD;
      end
      ST_COMPUTE: begin
        if (compute_end_s) state_nxt_s = ST_UNLOAD;
        else               state_nxt_s = ST_COMPUTE;
      end
      ST_UNLOAD: begin
        if (accept_s && out_last_r) state_nxt_s = ST_LOAD;
        else                        state_nxt_s = ST_UNLOAD;
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // Next values of the registered stream outputs and status flags
  always_comb begin
    in_ready_nxt_s = (state_nxt_s == ST_LOAD);
    busy_nxt_s     = (state_nxt_s != ST_LOAD);
    done_nxt_s     = 1'b0;
    if (load_beat_s) begin
      out_real_nxt_s  = rd_re_s;
      out_imag_nxt_s  = rd_im_s;
      out_idx_nxt_s   = (OUT_BITREV != 0) ? bitrev(k_load_s) : k_load_s;
      out_last_nxt_s  = (k_load_s == N_LOG2'(N - 1));
      out_valid_nxt_s = 1'b1;
    end else if (accept_s && out_last_r) begin
      out_real_nxt_s  = out_real_r;
      out_imag_nxt_s  = out_imag_r;
      out_idx_nxt_s   = out_idx_r;
      out_last_nxt_s  = 1'b0;
      out_valid_nxt_s = 1'b0;
      done_nxt_s      = 1'b1;
    end else begin
      out_real_nxt_s  = out_real_r;
      out_imag_nxt_s  = out_imag_r;
      out_idx_nxt_s   = out_idx_r;
      out_last_nxt_s  = out_last_r;
      out_valid_nxt_s = out_valid_r;
    end
  end

  // Output and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_real_r  <= '0;
      out_imag_r  <= '0;
      out_idx_r   <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      out_real_r  <= out_real_nxt_s;
      out_imag_r  <= out_imag_nxt_s;
      out_idx_r   <= out_idx_nxt_s;
      out_last_r  <= out_last_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  // Load, butterfly/stage and unload counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      bfly_r  <= '0;
      stage_r <= 4'd0;
      k_r     <= '0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (in_load_s) cnt_r <= cnt_r + N_LOG2'(1);
        end
        ST_COMPUTE: begin
          if (bfly_r == N_LOG2'(HN - 1)) begin
            bfly_r <= '0;
            if (stage_r == 4'(N_LOG2 - 1)) stage_r <= 4'd0;
            else                           stage_r <= stage_r + 4'd1;
          end else begin
            bfly_r <= bfly_r + N_LOG2'(1);
          end
        end
        ST_UNLOAD: begin
          if (accept_s) begin
            if (out_last_r) k_r <= '0;
            else            k_r <= k_r + N_LOG2'(1);
          end
        end
        default: begin
          cnt_r   <= '0;
          bfly_r  <= '0;
          stage_r <= 4'd0;
          k_r     <= '0;
        end
      endcase
    end
  end

  // Sample memory: written by input beats in LOAD and by both butterfly legs in COMPUTE
  always_ff @(posedge clk) begin
    if (in_load_s) begin
      mem_re_r[cnt_r] <= in_real;
      mem_im_r[cnt_r] <= in_imag;
    end else if (state_r == ST_COMPUTE) begin
      mem_re_r[p_s] <= bf_p_re_s;
      mem_im_r[p_s] <= bf_p_im_s;
      mem_re_r[q_s] <= bf_q_re_s;
      mem_im_r[q_s] <= bf_q_im_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_real  = out_real_r;
  assign out_imag  = out_imag_r;
  assign out_idx   = out_idx_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_fft_r2_dif_seq.sv
// Testbench for fft_r2_dif_seq: three instances (8-point natural, 8-point
// bit-reversed, 64-point natural) fed directed frames; expected beats are
// queued when a frame is sent and popped as the DUT streams them out.
module tb_fft_r2_dif_seq;

  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] d_re [3];
  logic [15:0] d_im [3];
  logic        d_val [3];
  logic        d_rdy [3];

  wire [15:0] ore_w [3];
  wire [15:0] oim_w [3];
  wire        oval_w [3];
  wire        olast_w [3];
  wire        obusy_w [3];
  wire        odone_w [3];
  wire        oirdy_w [3];
  wire [2:0]  oidx0, oidx1;
  wire [5:0]  oidx2;

  int   o_re [3];
  int   o_im [3];
  int   o_idx [3];
  logic o_val [3];
  logic o_last [3];
  logic o_busy [3];
  logic o_done [3];
  logic o_irdy [3];

  fft_r2_dif_seq #(.N_LOG2(3), .DW(16), .TW_W(16), .OUT_BITREV(0)) dut0 (
    .clk(clk), .rst(rst), .in_real(d_re[0]), .in_imag(d_im[0]), .in_valid(d_val[0]),
    .in_ready(oirdy_w[0]), .out_real(ore_w[0]), .out_imag(oim_w[0]), .out_idx(oidx0),
    .out_valid(oval_w[0]), .out_ready(d_rdy[0]), .out_last(olast_w[0]),
    .busy(obusy_w[0]), .done(odone_w[0]));

  fft_r2_dif_seq #(.N_LOG2(3), .DW(16), .TW_W(16), .OUT_BITREV(1)) dut1 (
    .clk(clk), .rst(rst), .in_real(d_re[1]), .in_imag(d_im[1]), .in_valid(d_val[1]),
    .in_ready(oirdy_w[1]), .out_real(ore_w[1]), .out_imag(oim_w[1]), .out_idx(oidx1),
    .out_valid(oval_w[1]), .out_ready(d_rdy[1]), .out_last(olast_w[1]),
    .busy(obusy_w[1]), .done(odone_w[1]));

  fft_r2_dif_seq #(.N_LOG2(6), .DW(16), .TW_W(16), .OUT_BITREV(0)) dut2 (
    .clk(clk), .rst(rst), .in_real(d_re[2]), .in_imag(d_im[2]), .in_valid(d_val[2]),
    .in_ready(oirdy_w[2]), .out_real(ore_w[2]), .out_imag(oim_w[2]), .out_idx(oidx2),
    .out_valid(oval_w[2]), .out_ready(d_rdy[2]), .out_last(olast_w[2]),
    .busy(obusy_w[2]), .done(odone_w[2]));

  // Gather the three instances' outputs into indexable arrays
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      o_re[i]   = int'($signed(ore_w[i]));
      o_im[i]   = int'($signed(oim_w[i]));
      o_val[i]  = oval_w[i];
      o_last[i] = olast_w[i];
      o_busy[i] = obusy_w[i];
      o_done[i] = odone_w[i];
      o_irdy[i] = oirdy_w[i];
    end
    o_idx[0] = int'(oidx0);
    o_idx[1] = int'(oidx1);
    o_idx[2] = int'(oidx2);
  end

  typedef struct {
    int idx;
    int re;
    int im;
    int last;
    int tol;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   st_re [64];
  int   st_im [64];
  int   bin_re [64];
  int   bin_im [64];

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int expv, input int tol);
    n_assert++;
    assert (((obs - expv) <= tol) && ((expv - obs) <= tol)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
    end
  endtask

  function automatic int brev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) if (((v >> i) & 1) != 0) r = r | (1 << (bits - 1 - i));
    return r;
  endfunction

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(0.5 - r);
  endfunction

  function automatic int trunc16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic clear_frame(input int n);
    for (int i = 0; i < n; i++) begin
      st_re[i]  = 0;
      st_im[i]  = 0;
      bin_re[i] = 0;
      bin_im[i] = 0;
    end
  endtask

  // Queue the expected beats of one frame in the order the instance emits them
  task automatic push_frame(input int n, input int nlog2, input bit brev_order, input int tol);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.idx  = brev_order ? brev(k, nlog2) : k;
      e.re   = bin_re[e.idx];
      e.im   = bin_im[e.idx];
      e.last = (k == n - 1) ? 1 : 0;
      e.tol  = tol;
      sb.push_back(e);
    end
  endtask

  // Reference DIF transform with halving per stage and truncation of the twiddle product
  task automatic ref_model(input int n, input int nlog2);
    int m_re [64];
    int m_im [64];
    int h, p, q, j, tr, ti, ar, ai, br, bi, dr, di;
    longint pr, pim;
    for (int i = 0; i < n; i++) begin
      m_re[i] = st_re[i];
      m_im[i] = st_im[i];
    end
    for (int s = 0; s < nlog2; s++) begin
      h = n >> (s + 1);
      for (int b = 0; b < n / 2; b++) begin
        j  = b % h;
        p  = (b / h) * 2 * h + j;
        q  = p + h;
        tr = rnd($cos(2.0 * PI * real'(j << s) / real'(n)) * 16384.0);
        ti = rnd(-$sin(2.0 * PI * real'(j << s) / real'(n)) * 16384.0);
        ar = m_re[p]; ai = m_im[p]; br = m_re[q]; bi = m_im[q];
        dr = (ar - br) >>> 1;
        di = (ai - bi) >>> 1;
        pr  = longint'(dr) * longint'(tr) - longint'(di) * longint'(ti);
        pim = longint'(dr) * longint'(ti) + longint'(di) * longint'(tr);
        m_re[p] = (ar + br) >>> 1;
        m_im[p] = (ai + bi) >>> 1;
        m_re[q] = trunc16(pr >>> 14);
        m_im[q] = trunc16(pim >>> 14);
      end
    end
    for (int k = 0; k < n; k++) begin
      bin_re[k] = m_re[brev(k, nlog2)];
      bin_im[k] = m_im[brev(k, nlog2)];
    end
  endtask

  task automatic send(input int sel, input int n, input bit keep_valid);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("in_ready_load s%0d", i), int'(o_irdy[sel]), 1);
      d_re[sel]  = 16'(st_re[i]);
      d_im[sel]  = 16'(st_im[i]);
      d_val[sel] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!keep_valid) d_val[sel] = 1'b0;
  endtask

  // Drain one frame, comparing each beat with the scoreboard head
  task automatic collect(input int sel, input int n, input int stall_at, input int lat_exp,
                         input bit chk_busy_in);
    exp_t e;
    int waited, h_re, h_im, h_idx, h_last;
    d_rdy[sel] = 1'b1;
    for (int b = 0; b < n; b++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!o_val[sel] && waited < 1000);
      if (!o_val[sel]) begin
        chk($sformatf("valid_timeout b%0d", b), int'(o_val[sel]), 1);
        return;
      end
      if (b == 0 && lat_exp > 0) chk("latency_to_first_valid", waited, lat_exp);
      if (chk_busy_in) begin
        chk($sformatf("in_ready_busy b%0d", b), int'(o_irdy[sel]), 0);
        chk($sformatf("busy b%0d", b), int'(o_busy[sel]), 1);
      end
      if (b == stall_at) begin
        h_re = o_re[sel]; h_im = o_im[sel]; h_idx = o_idx[sel]; h_last = int'(o_last[sel]);
        d_rdy[sel] = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk($sformatf("stall_valid c%0d", c), int'(o_val[sel]), 1);
          chk($sformatf("stall_re c%0d", c), o_re[sel], h_re);
          chk($sformatf("stall_im c%0d", c), o_im[sel], h_im);
          chk($sformatf("stall_idx c%0d", c), o_idx[sel], h_idx);
          chk($sformatf("stall_last c%0d", c), int'(o_last[sel]), h_last);
        end
        d_rdy[sel] = 1'b1;
      end
      if (sb.size() == 0) begin
        chk("scoreboard_underflow", sb.size(), 1);
        return;
      end
      e = sb.pop_front();
      chk($sformatf("idx b%0d", b), o_idx[sel], e.idx);
      chk_tol($sformatf("re bin%0d", e.idx), o_re[sel], e.re, e.tol);
      chk_tol($sformatf("im bin%0d", e.idx), o_im[sel], e.im, e.tol);
      chk($sformatf("last b%0d", b), int'(o_last[sel]), e.last);
    end
    @(negedge clk);
    d_val[sel] = 1'b0;
    chk("done_pulse", int'(o_done[sel]), 1);
    chk("valid_after_last", int'(o_val[sel]), 0);
    chk("in_ready_after_last", int'(o_irdy[sel]), 1);
    chk("busy_after_last", int'(o_busy[sel]), 0);
    @(negedge clk);
    chk("done_single_cycle", int'(o_done[sel]), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_re[i] = 16'd0; d_im[i] = 16'd0; d_val[i] = 1'b0; d_rdy[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(o_irdy[0]), 1);
    chk("rst_out_valid", int'(o_val[0]), 0);
    chk("rst_busy", int'(o_busy[0]), 0);
    chk("rst_done", int'(o_done[0]), 0);
    chk("rst_out_last", int'(o_last[0]), 0);
    chk("rst_out_real", o_re[0], 0);
    chk("rst_out_idx", o_idx[0], 0);
    rst = 1'b0;

    // Impulse: every bin 125+0j, plus latency from last input to first output
    clear_frame(8);
    st_re[0] = 1000;
    for (int k = 0; k < 8; k++) bin_re[k] = 125;
    push_frame(8, 3, 1'b0, 0);
    send(0, 8, 1'b0);
    collect(0, 8, -1, 13, 1'b0);

    // DC: only bin 0 carries energy
    clear_frame(8);
    for (int i = 0; i < 8; i++) st_re[i] = 800;
    bin_re[0] = 800;
    push_frame(8, 3, 1'b0, 0);
    send(0, 8, 1'b0);
    collect(0, 8, -1, 0, 1'b0);

    // Alternating sign: only bin 4, natural then bit-reversed order
    clear_frame(8);
    for (int i = 0; i < 8; i++) st_re[i] = ((i % 2) == 0) ? 800 : -800;
    bin_re[4] = 800;
    push_frame(8, 3, 1'b0, 0);
    send(0, 8, 1'b0);
    collect(0, 8, -1, 0, 1'b0);
    push_frame(8, 3, 1'b1, 0);
    send(1, 8, 1'b0);
    collect(1, 8, -1, 0, 1'b0);

    // Backpressure at beat 3 with in_valid held high while busy
    clear_frame(8);
    for (int i = 0; i < 8; i++) st_re[i] = 800;
    bin_re[0] = 800;
    push_frame(8, 3, 1'b0, 0);
    send(0, 8, 1'b1);
    collect(0, 8, 3, 0, 1'b1);

    // Following impulse frame shows no stray sample was taken while busy
    clear_frame(8);
    st_re[0] = 1000;
    for (int k = 0; k < 8; k++) bin_re[k] = 125;
    push_frame(8, 3, 1'b0, 0);
    send(0, 8, 1'b0);
    collect(0, 8, -1, 0, 1'b0);

    // Reset in the middle of COMPUTE aborts the frame
    send(0, 8, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(o_irdy[0]), 1);
    chk("midrst_out_valid", int'(o_val[0]), 0);
    chk("midrst_busy", int'(o_busy[0]), 0);
    rst = 1'b0;
    push_frame(8, 3, 1'b0, 0);
    send(0, 8, 1'b0);
    collect(0, 8, -1, 0, 1'b0);

    // 64-point random full-scale frame against the reference model
    clear_frame(64);
    for (int i = 0; i < 64; i++) begin
      st_re[i] = int'($urandom_range(65535)) - 32768;
      st_im[i] = int'($urandom_range(65535)) - 32768;
    end
    ref_model(64, 6);
    push_frame(64, 6, 1'b0, 6);
    send(2, 64, 1'b0);
    collect(2, 64, -1, 0, 1'b0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
